game_countdown_timer: RTL and testbench

GAME_COUNTDOWN_TIMER -- requirements
Module: game_countdown_timer

---
 rtl/game_countdown_timer.sv | 123 ++++++++++++
 tb/tb_game_countdown_timer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/game_countdown_timer.sv
// Two-digit BCD countdown timer for a game clock. Counts ms_tick pulses
// in RUN and decrements the displayed seconds every MS_PER_SEC ticks.
module game_countdown_timer #(
    parameter int unsigned MS_PER_SEC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    input  logic       ms_tick,
    output logic       tick_en,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       timeout,
    output logic       expired
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StPaused = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic [9:0] MsMax = 10'(MS_PER_SEC - 1);

    logic [1:0] state_q, state_d;
    logic [9:0] ms_cnt_q, ms_cnt_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       timeout_q, timeout_d;

    // Next-state: load wins over everything, then per-state behaviour
    always_comb begin
        state_d   = state_q;
        ms_cnt_d  = ms_cnt_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        timeout_d = 1'b0;

        if (load) begin
            // Out-of-range BCD digits saturate to 9
            tens_d   = (load_tens > 4'd9) ? 4'd9 : load_tens;
            ones_d   = (load_ones > 4'd9) ? 4'd9 : load_ones;
            ms_cnt_d = '0;
            state_d  = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (tens_q == 4'd0 && ones_q == 4'd0) begin
                            state_d   = StDone;
                            timeout_d = 1'b1;
                        end else begin
                            state_d = StRun;
                        end
                    end
                end
                StRun: begin
                    // A tick coincident with pause is dropped
                    if (pause) begin
                        state_d = StPaused;
                    end else if (ms_tick) begin
                        if (ms_cnt_q == MsMax) begin
                            ms_cnt_d = '0;
                            if (ones_q != 4'd0) begin
                                ones_d = ones_q - 4'd1;
                            end else if (tens_q != 4'd0) begin
                                ones_d = 4'd9;
                                tens_d = tens_q - 4'd1;
                            end
                            // Reaching 00 happens only from 01
                            if (tens_q == 4'd0 && ones_q <= 4'd1) begin
                                state_d   = StDone;
                                timeout_d = 1'b1;
                            end
                        end else begin
                            ms_cnt_d = ms_cnt_q + 10'd1;
                        end
                    end
                end
                StPaused: begin
                    if (start && !pause) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    // StDone: held until load or rst
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ms_cnt_q  <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ms_cnt_q  <= ms_cnt_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs decoded directly from registered state
    always_comb begin
        tick_en = (state_q == StRun);
        running = (state_q == StRun);
        expired = (state_q == StDone);
        tens    = tens_q;
        ones    = ones_q;
        timeout = timeout_q;
    end

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer with MS_PER_SEC=4.
module tb_game_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_tens = '0;
    logic [3:0] load_ones = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       ms_tick = 1'b0;
    logic       tick_en;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       timeout;
    logic       expired;

    int tests = 0;
    int fails = 0;

    game_countdown_timer #(.MS_PER_SEC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_tens (load_tens),
        .load_ones (load_ones),
        .start     (start),
        .pause     (pause),
        .ms_tick   (ms_tick),
        .tick_en   (tick_en),
        .tens      (tens),
        .ones      (ones),
        .running   (running),
        .timeout   (timeout),
        .expired   (expired)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling/driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] digits, input logic run,
                            input logic to, input logic exp_d);
        chk({tag, ".digits"}, {24'd0, tens, ones}, {24'd0, digits});
        chk({tag, ".running"}, {31'd0, running}, {31'd0, run});
        chk({tag, ".tick_en"}, {31'd0, tick_en}, {31'd0, run});
        chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, to});
        chk({tag, ".expired"}, {31'd0, expired}, {31'd0, exp_d});
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        load = 1'b1; load_tens = t; load_ones = o;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_tick();
        ms_tick = 1'b1;
        step();
        ms_tick = 1'b0;
    endtask

    initial begin
        #1;
        // Reset state
        rst = 1'b1;
        step();
        chk_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset.ms_cnt", {22'd0, dut.ms_cnt_q}, 32'd0);
        rst = 1'b0;
        step();
        step();
        chk_outs("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);

        // Basic countdown from 02
        do_load(4'd0, 4'd2);
        chk_outs("basic.load", 8'h02, 1'b0, 1'b0, 1'b0);
        do_start();
        chk_outs("basic.start", 8'h02, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) do_tick();
        chk_outs("basic.t3", 8'h02, 1'b1, 1'b0, 1'b0);
        chk("basic.t3.ms_cnt", {22'd0, dut.ms_cnt_q}, 32'd3);
        do_tick();
        chk_outs("basic.t4", 8'h01, 1'b1, 1'b0, 1'b0);
        chk("basic.t4.ms_cnt", {22'd0, dut.ms_cnt_q}, 32'd0);
        for (int i = 5; i <= 7; i++) do_tick();
        chk_outs("basic.t7", 8'h01, 1'b1, 1'b0, 1'b0);
        do_tick();
        chk_outs("basic.t8", 8'h00, 1'b0, 1'b1, 1'b1);
        step();
        chk_outs("basic.after", 8'h00, 1'b0, 1'b0, 1'b1);

        // Ones borrow 10 -> 09
        do_load(4'd1, 4'd0);
        chk_outs("borrow.load", 8'h10, 1'b0, 1'b0, 1'b0);
        do_start();
        for (int i = 0; i < 4; i++) do_tick();
        chk_outs("borrow.t4", 8'h09, 1'b1, 1'b0, 1'b0);

        // Pause and resume from 01
        do_load(4'd0, 4'd1);
        do_start();
        do_tick();
        do_tick();
        chk("pause.ms_cnt2", {22'd0, dut.ms_cnt_q}, 32'd2);
        pause = 1'b1; ms_tick = 1'b1;   // coincident tick must be dropped
        step();
        pause = 1'b0; ms_tick = 1'b0;
        chk_outs("pause.enter", 8'h01, 1'b0, 1'b0, 1'b0);
        chk("pause.enter.ms_cnt", {22'd0, dut.ms_cnt_q}, 32'd2);
        for (int i = 0; i < 5; i++) do_tick();
        chk_outs("pause.ticks", 8'h01, 1'b0, 1'b0, 1'b0);
        chk("pause.ticks.ms_cnt", {22'd0, dut.ms_cnt_q}, 32'd2);
        do_start();
        chk_outs("pause.resume", 8'h01, 1'b1, 1'b0, 1'b0);
        chk("pause.resume.ms_cnt", {22'd0, dut.ms_cnt_q}, 32'd2);
        do_tick();
        chk_outs("pause.t3", 8'h01, 1'b1, 1'b0, 1'b0);
        do_tick();
        chk_outs("pause.t4", 8'h00, 1'b0, 1'b1, 1'b1);

        // Load edge cases
        do_load(4'hA, 4'hF);
        chk_outs("load.clamp", 8'h99, 1'b0, 1'b0, 1'b0);
        do_load(4'd0, 4'd0);
        do_start();
        chk_outs("load.zero_start", 8'h00, 1'b0, 1'b1, 1'b1);
        load = 1'b1; start = 1'b1; load_tens = 4'd3; load_ones = 4'd4;
        step();
        load = 1'b0; start = 1'b0;
        chk_outs("load.with_start", 8'h34, 1'b0, 1'b0, 1'b0);
        do_tick();
        chk_outs("idle.tick_ignored", 8'h34, 1'b0, 1'b0, 1'b0);
        chk("idle.tick.ms_cnt", {22'd0, dut.ms_cnt_q}, 32'd0);

        // Reset mid-run with ms_cnt=3 and coincident tick
        do_start();
        for (int i = 0; i < 3; i++) do_tick();
        chk("rst.pre.ms_cnt", {22'd0, dut.ms_cnt_q}, 32'd3);
        rst = 1'b1; ms_tick = 1'b1;
        step();
        rst = 1'b0; ms_tick = 1'b0;
        chk_outs("rst.mid", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst.mid.ms_cnt", {22'd0, dut.ms_cnt_q}, 32'd0);
        // Reset beats a coincident load
        rst = 1'b1; load = 1'b1; load_tens = 4'd7; load_ones = 4'd7;
        step();
        rst = 1'b0; load = 1'b0;
        chk_outs("rst.load", 8'h00, 1'b0, 1'b0, 1'b0);

        // DONE lock
        do_load(4'd0, 4'd0);
        do_start();
        step();
        start = 1'b1; ms_tick = 1'b1; pause = 1'b1;
        step();
        start = 1'b0; ms_tick = 1'b0; pause = 1'b0;
        chk_outs("done.lock", 8'h00, 1'b0, 1'b0, 1'b1);
        do_load(4'd0, 4'd5);
        chk_outs("done.reload", 8'h05, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
